noc_src_arbiter: RTL and testbench
==================================

Name: noc_src_arbiter

Overview:
- Shares the single packet-injection port of noc_router between NUM_SRC packet sources (packet_gen instances or IP endpoints).
- Round-robin arbitration with a per-owner burst limit feeds one registered output slot that drives the router's packet/src_valid/src_ready handshake.
- Packets of the reserved type are filtered and counted; they are never forwarded.

Parameters:
- NUM_SRC, 4, number of requesters (2..8)
- PKT_W, 13, packet width; bit layout fixed by the package
- MAX_BURST, 4, max consecutive accepts granted to one owner before forced rotation (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (asserted when 0, sampled on rising clk)
- req_valid  in  NUM_SRC  per-source packet valid
- req_ready  out  NUM_SRC  per-source accept; at most one bit high
- req_packet  in  NUM_SRC*PKT_W  per-source packet, source i at [i*PKT_W +: PKT_W]
- out_valid  out  1  to router src_valid
- out_ready  in  1  from router src_ready
- out_packet  out  PKT_W  to router packet
- grant_id  out  $clog2(NUM_SRC)  source index of the packet currently in out_packet
- drop_cnt  out  8  saturating count of dropped reserved-type packets

Behaviour:
- Packet layout: [12:11] type (00 DATA, 01 CTRL, 10 RESP, 11 RSVD), [10:8] tag, [7:0] payload.
- Reset (rst=0 at a rising edge) clears the following: out_valid=0, out_packet=0, grant_id=0, drop_cnt=0, rr_ptr=0, owner=0, burst_cnt=0, state=IDLE. req_ready is 0 during reset. A packet held mid-transfer is discarded.
- slot_free = !out_valid || out_ready. Accepts happen only when slot_free.
- FSM has two states:
  - IDLE: no owner. When slot_free and any req_valid, grant the first valid index searching from rr_ptr upward with wrap. Set owner to that index and go to OWN.
  - OWN: the owner keeps the grant while req_valid[owner]=1 and burst_cnt<MAX_BURST.
    - If the owner drops valid, or burst_cnt reaches MAX_BURST: set rr_ptr=(owner+1)%NUM_SRC, clear burst_cnt, and re-arbitrate in the same cycle. This is a combinational search excluding nothing, starting at the new rr_ptr.
    - If no source is valid, go to IDLE.
- req_ready[i] is combinational: req_ready[i] = slot_free && (i == selected index). It never depends on req_valid[i] of a non-selected source.
- Accept = req_valid[sel] && req_ready[sel]. On accept, burst_cnt increments.
- Accept of a non-RSVD packet: the next cycle has out_valid=1, out_packet=packet, grant_id=sel. Latency is 1 cycle and sustained throughput is 1 packet per cycle.
- Accept of an RSVD packet: dropped; out_valid is cleared if slot_free; drop_cnt increments and saturates at 255; the packet counts toward burst_cnt.
- Output hold: while out_valid && !out_ready, out_packet and grant_id stay stable and all req_ready are 0.
- Simultaneous out_ready and a new accept: the slot is replaced in the same edge with no bubble.
- Simultaneous valid on all sources with out_ready=1 constantly: a grant sequence of MAX_BURST packets per source in index order.
- NUM_SRC=1: always grants source 0; burst rotation wraps onto itself, with no idle cycle inserted.

Decomposition:
- noc_pkg holds:
  - pkt_type_e enum (PKT_DATA, PKT_CTRL, PKT_RESP, PKT_RSVD)
  - PKT_W=13 and the field position constants TYPE_MSB/LSB, TAG_MSB/LSB, PAY_MSB/LSB
  - noc_packet_t packed struct
  - arb_state_e (ARB_IDLE, ARB_OWN)
- One sub-module, rr_pick: a combinational round-robin first-valid search. It has NUM_SRC as a parameter, takes inputs req and ptr, and outputs idx and found. It is reused by the router's output arbiters.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req_valid=1 -> out_valid=0, req_ready=0, drop_cnt=0. On release, the first grant goes to source 0.
- Round-robin with burst, NUM_SRC=4, MAX_BURST=2, all sources valid, out_ready=1 -> grant_id sequence 0,0,1,1,2,2,3,3,0.
- Backpressure: one packet 13'h0A5 from src 2 with out_ready=0 for 5 cycles -> out_packet=13'h0A5 stable, grant_id=2, req_ready all 0. Packet consumed the cycle after out_ready=1.
- RSVD drop: src 1 sends 13'h1800 then 13'h0812 -> the first is never seen on out_valid, drop_cnt=1. The second appears 1 cycle after its accept.
- Drop saturation: 300 RSVD packets -> drop_cnt=255, out_valid stays 0.
- Owner release: src 3 valid for 1 packet, then low while src 0 valid -> src 0 is granted the next cycle (rr_ptr=0), with no idle cycle between outputs.

Source files
------------

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared NoC packet layout, packet types and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int PKT_W    = 13;
    localparam int TYPE_MSB = 12;
    localparam int TYPE_LSB = 11;
    localparam int TAG_MSB  = 10;
    localparam int TAG_LSB  = 8;
    localparam int PAY_MSB  = 7;
    localparam int PAY_LSB  = 0;

    typedef enum logic [1:0] {
        PKT_DATA = 2'b00,
        PKT_CTRL = 2'b01,
        PKT_RESP = 2'b10,
        PKT_RSVD = 2'b11
    } pkt_type_e;

    typedef struct packed {
        pkt_type_e   ptype;
        logic [2:0]  tag;
        logic [7:0]  payload;
    } noc_packet_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    function automatic logic is_rsvd(input noc_packet_t pkt);
        return pkt.ptype == PKT_RSVD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin first-valid search starting at ptr.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_SRC]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + k) % NUM_SRC);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_src_arbiter
// Purpose  : Round-robin, burst-limited share of the router injection port;
//            reserved-type packets are dropped and counted.
// Revision : 1.0
// ============================================================================
module noc_src_arbiter #(
    parameter  int NUM_SRC   = 4,
    parameter  int PKT_W     = 13,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       req_valid,
    output logic [NUM_SRC-1:0]       req_ready,
    input  logic [NUM_SRC*PKT_W-1:0] req_packet,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PKT_W-1:0]         out_packet,
    output logic [IDX_W-1:0]         grant_id,
    output logic [7:0]               drop_cnt
);
    import noc_pkg::*;

    localparam logic [3:0] c_burst_lim = 4'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [PKT_W-1:0]   out_packet_q, out_packet_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               w_slot_free;
    logic               w_keep;
    logic               w_release;
    logic [IDX_W-1:0]   w_owner_next;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic [IDX_W-1:0]   w_sel;
    logic               w_sel_found;
    logic               w_accept;
    logic [PKT_W-1:0]   w_sel_pkt;
    logic               w_sel_rsvd;

    // The owner holds the grant until it idles or exhausts its burst; after
    // that the search restarts just past it so every source gets a turn.
    always_comb begin
        w_slot_free  = !out_valid_q || out_ready;
        w_owner_next = (owner_q == IDX_W'(NUM_SRC - 1)) ? '0 : owner_q + IDX_W'(1);
        w_keep       = (state_q == ARB_OWN) && req_valid[owner_q] && (burst_cnt_q < c_burst_lim);
        w_release    = (state_q == ARB_OWN) && !w_keep;
        w_pick_ptr   = (state_q == ARB_OWN) ? w_owner_next : rr_ptr_q;
        w_sel        = w_keep ? owner_q : w_pick_idx;
        w_sel_found  = w_keep || w_pick_found;
        w_accept     = rst && w_slot_free && w_sel_found;
        w_sel_pkt    = req_packet[int'(w_sel)*PKT_W +: PKT_W];
        w_sel_rsvd   = is_rsvd(noc_packet_t'(w_sel_pkt));
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (w_pick_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (w_release) begin
            rr_ptr_d    = w_owner_next;
            burst_cnt_d = '0;
            state_d     = ARB_IDLE;
        end
        if (w_accept) begin
            state_d     = ARB_OWN;
            owner_d     = w_sel;
            burst_cnt_d = (w_keep ? burst_cnt_q : 4'd0) + 4'd1;
        end
    end

    // Reserved packets are consumed like any other accept but never occupy the slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        grant_id_d   = grant_id_q;
        drop_cnt_d   = drop_cnt_q;
        if (w_slot_free) begin
            out_valid_d = 1'b0;
        end
        if (w_accept) begin
            if (w_sel_rsvd) begin
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end else begin
                out_valid_d  = 1'b1;
                out_packet_d = w_sel_pkt;
                grant_id_d   = w_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            grant_id_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            grant_id_q   <= grant_id_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign grant_id   = grant_id_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_src_arbiter
// Purpose  : Directed self-checking bench for noc_src_arbiter (4 sources, burst 2).
// Revision : 1.0
// ============================================================================
module tb_noc_src_arbiter;

    localparam int NUM_SRC   = 4;
    localparam int PKT_W     = 13;
    localparam int MAX_BURST = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_SRC-1:0]       req_valid;
    logic [NUM_SRC-1:0]       req_ready;
    logic [NUM_SRC*PKT_W-1:0] req_packet;
    logic                     out_valid;
    logic                     out_ready;
    logic [PKT_W-1:0]         out_packet;
    logic [1:0]               grant_id;
    logic [7:0]               drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_src_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .PKT_W     (PKT_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_packet (req_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .grant_id   (grant_id),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int s, input logic [PKT_W-1:0] p);
        req_packet[s*PKT_W +: PKT_W] = p;
    endtask

    // Default DATA packet of source i: tag=i, payload=A0+i.
    function automatic logic [PKT_W-1:0] pkt_of(input int i);
        return {2'b00, 3'(i), 8'(8'hA0 + i)};
    endfunction

    int exp_g [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int exp_drop;

    initial begin
        rst        = 1'b0;
        req_valid  = 4'hF;
        out_ready  = 1'b1;
        req_packet = '0;
        for (int i = 0; i < NUM_SRC; i++) set_pkt(i, pkt_of(i));

        repeat (3) begin
            tick();
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
        end
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_grant_id", 32'(grant_id), 0);

        rst = 1'b1;
        #1;
        chk("first_ready", 32'(req_ready), 32'h1);

        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rr_valid",  32'(out_valid),  1);
            chk("rr_grant",  32'(grant_id),   exp_g[k]);
            chk("rr_packet", 32'(out_packet), 32'(pkt_of(exp_g[k])));
        end

        req_valid = 4'b0000;
        tick();
        tick();
        chk("drain_valid", 32'(out_valid), 0);

        set_pkt(2, 13'h0A5);
        req_valid = 4'b0100;
        out_ready = 1'b0;
        #1;
        chk("bp_ready_pre", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid",  32'(out_valid),  1);
            chk("bp_hold_packet", 32'(out_packet), 32'h0A5);
            chk("bp_hold_grant",  32'(grant_id),   2);
            chk("bp_hold_ready",  32'(req_ready),  0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        tick();
        chk("bp_replace_valid",  32'(out_valid),  1);
        chk("bp_replace_packet", 32'(out_packet), 32'(pkt_of(0)));
        chk("bp_replace_grant",  32'(grant_id),   0);
        req_valid = 4'b0000;
        tick();
        chk("bp_empty_valid", 32'(out_valid), 0);

        set_pkt(1, 13'h1800);
        req_valid = 4'b0010;
        #1;
        chk("rsvd_ready", 32'(req_ready), 32'h2);
        tick();
        chk("rsvd_valid", 32'(out_valid), 0);
        chk("rsvd_drop",  32'(drop_cnt),  1);
        set_pkt(1, 13'h0812);
        tick();
        chk("rsvd_next_valid",  32'(out_valid),  1);
        chk("rsvd_next_packet", 32'(out_packet), 32'h0812);
        chk("rsvd_next_grant",  32'(grant_id),   1);

        set_pkt(1, 13'h1800);
        for (int k = 0; k < 300; k++) begin
            tick();
            exp_drop = (k + 2 > 255) ? 255 : k + 2;
            chk("sat_valid", 32'(out_valid), 0);
            chk("sat_drop",  32'(drop_cnt),  exp_drop);
        end

        req_valid = 4'b0000;
        tick();
        set_pkt(1, pkt_of(1));
        set_pkt(3, 13'h0733);
        req_valid = 4'b1000;
        #1;
        chk("own_ready3", 32'(req_ready), 32'h8);
        tick();
        chk("own_valid3",  32'(out_valid),  1);
        chk("own_grant3",  32'(grant_id),   3);
        chk("own_packet3", 32'(out_packet), 32'h0733);
        req_valid = 4'b0001;
        #1;
        chk("own_ready0", 32'(req_ready), 32'h1);
        tick();
        chk("own_valid0",  32'(out_valid),  1);
        chk("own_grant0",  32'(grant_id),   0);
        chk("own_packet0", 32'(out_packet), 32'(pkt_of(0)));
        req_valid = 4'b0000;
        tick();
        chk("own_end_valid", 32'(out_valid), 0);
        chk("own_end_drop",  32'(drop_cnt),  255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
